// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Parametrised pipeline-stage register with a valid/ready handshake, used
//   between core stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a payload
//   and a control field. Control bits are forced to zero whenever the stage
//   holds a bubble, so empty or killed slots can never write memory or the
//   register file.
//
//   SKID=1: two entries (main M + skid S). in_ready comes straight from a
//           flop, so the ready path is fully registered.
//   SKID=0: single entry. in_ready = ~M.valid | out_ready (combinational).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream has a beat
//   in_ready   stage can accept a beat
//   in_data    upstream payload (never masked)
//   in_ctrl    upstream control bits
//   flush      kill every held beat; a beat accepted in the same cycle is lost
//   out_valid  stage holds a beat for downstream
//   out_ready  downstream accepts
//   out_data   payload of head beat; keeps its last value while empty
//   out_ctrl   control of head beat; all-zero while out_valid=0
//   stall_cnt  saturating count of edges with out_valid=1 and out_ready=0
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam bit HAS_SKID = (SKID != 0);

  // Main entry (drives the outputs)
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic              m_valid_nxt;
  logic [DATA_W-1:0] m_data_nxt;
  logic [CTRL_W-1:0] m_ctrl_nxt;

  // Skid entry (stays empty when SKID=0)
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic              s_valid_nxt;
  logic [DATA_W-1:0] s_data_nxt;
  logic [CTRL_W-1:0] s_ctrl_nxt;

  logic              in_ready_q;
  logic              accept;
  logic              m_free;

  assign in_ready  = HAS_SKID ? in_ready_q : (~m_valid | out_ready);
  assign accept    = in_valid & in_ready;
  // M can take a new beat at this edge if it is empty or its beat leaves now
  assign m_free    = ~m_valid | out_ready;

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_valid ? m_ctrl : '0;

  // Next-state for the storage entries
  always_comb begin
    m_valid_nxt = m_valid;
    m_data_nxt  = m_data;
    m_ctrl_nxt  = m_ctrl;
    s_valid_nxt = s_valid;
    s_data_nxt  = s_data;
    s_ctrl_nxt  = s_ctrl;

    if (HAS_SKID) begin
      if (m_free) begin
        if (s_valid) begin
          // Older skid beat advances first so arrival order is preserved;
          // any beat accepted alongside it takes the skid slot.
          m_valid_nxt = 1'b1;
          m_data_nxt  = s_data;
          m_ctrl_nxt  = s_ctrl;
          s_valid_nxt = accept;
          if (accept) begin
            s_data_nxt = in_data;
            s_ctrl_nxt = in_ctrl;
          end
        end else begin
          m_valid_nxt = accept;
          if (accept) begin
            m_data_nxt = in_data;
            m_ctrl_nxt = in_ctrl;
          end
        end
      end else if (accept) begin
        s_valid_nxt = 1'b1;
        s_data_nxt  = in_data;
        s_ctrl_nxt  = in_ctrl;
      end
    end else begin
      s_valid_nxt = 1'b0;
      if (accept) begin
        m_valid_nxt = 1'b1;
        m_data_nxt  = in_data;
        m_ctrl_nxt  = in_ctrl;
      end else if (m_valid && out_ready) begin
        m_valid_nxt = 1'b0;
      end
    end
  end

  // Storage registers. Flush clears only the valid bits; payload keeps its
  // last value so out_data holds while the stage is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_ctrl     <= '0;
      s_valid    <= 1'b0;
      s_data     <= '0;
      s_ctrl     <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      m_valid    <= m_valid_nxt;
      m_data     <= m_data_nxt;
      m_ctrl     <= m_ctrl_nxt;
      s_valid    <= s_valid_nxt;
      s_data     <= s_data_nxt;
      s_ctrl     <= s_ctrl_nxt;
      // Registered ready: open exactly when the skid slot will be empty
      in_ready_q <= ~s_valid_nxt;
    end
  end

  // Stall counter: saturating, unaffected by flush
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (m_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline-stage register that replaces fixed per-signal flop banks between core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a payload field and a control field with a valid/ready handshake.
- Supports flush (kill) and stall (backpressure).
- Optional skid buffer gives a fully registered ready path.
- Control bits are forced to zero whenever the stage holds a bubble, so killed or empty slots never write memory or the register file.

Parameters:
DATA_W, 128, payload width (operands, immediates, PC, register indices); never masked.
CTRL_W, 12, control width (branch, alu_op, mem_read/write, reg_write, memtoreg, ...); zeroed on bubble.
SKID, 1, 1 = two-entry main+skid with registered in_ready; 0 = single entry, combinational in_ready.
CNT_W, 16, width of stall-cycle counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; synchronous, active-high.
in_valid  in  1  upstream has a beat.
in_ready  out  1  stage can accept a beat.
in_data  in  DATA_W  upstream payload.
in_ctrl  in  CTRL_W  upstream control bits.
flush  in  1  kill all held beats (branch mispredict / trap).
out_valid  out  1  stage holds a beat for downstream.
out_ready  in  1  downstream accepts.
out_data  out  DATA_W  payload of head beat.
out_ctrl  out  CTRL_W  control of head beat; all-zero when out_valid=0.
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshakes:
  - Accept when in_valid & in_ready at a rising edge.
  - Emit when out_valid & out_ready at a rising edge.
  - Beats leave in arrival order; no beat is dropped or duplicated except by flush.
- Storage:
  - Main entry M drives the outputs.
  - Skid entry S exists only when SKID=1.
  - out_valid = M.valid.
  - out_data = M.data; holds the last value when invalid.
  - out_ctrl = M.valid ? M.ctrl : 0.
- SKID=0:
  - in_ready = ~M.valid | out_ready (combinational).
  - On accept, M loads the input.
  - On emit without accept, M.valid clears.
- SKID=1:
  - in_ready = ~S.valid, driven from a flop.
  - M is free next cycle if ~M.valid or emitting.
  - If M is free and S is valid, M loads S and S clears; an input accepted in the same cycle goes to S.
  - If M is free and S is empty, an accepted input goes to M.
  - If M is not free, an accepted input goes to S.
- Latency and throughput:
  - Latency: 1 cycle from input accept to out_valid.
  - Full throughput of 1 beat/cycle with out_ready=1 in both modes.
- Flush (priority below rst, above all else):
  - At the edge: M.valid=0, S.valid=0.
  - A beat accepted in the flush cycle is discarded.
  - Next cycle: out_valid=0, out_ctrl=0, in_ready=1.
  - stall_cnt is not affected.
- Reset (rst=1 at edge):
  - M.valid=0, S.valid=0, out_data=0, out_ctrl=0, stall_cnt=0.
  - in_ready=1 from the first cycle after reset.
  - Inputs are ignored while rst=1.
  - Reset mid-transfer loses held beats with no partial state left behind.
- stall_cnt:
  - Increments every edge where out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst.
- Simultaneous events:
  - Emit and accept in the same cycle are legal in both modes.
  - In SKID=1 with S full: S moves to M, S clears, and in_ready rises next cycle.

Test Plan:
1. Reset: hold rst 2 cycles with in_valid=1, in_ctrl=0xFFF -> after release out_valid=0, out_ctrl=0x000, out_data=0, in_ready=1, stall_cnt=0.
2. Streaming (SKID=1, out_ready=1): in_data=1..8 on consecutive cycles -> out_data=1..8 one cycle later, out_valid continuous for 8 cycles, in_ready never low.
3. Backpressure (SKID=1): out_ready=0, send A,B,C -> A in M, B in S, in_ready=0 the cycle after B is accepted, C held upstream. Raise out_ready -> outputs A,B,C in order, in_ready=1 the cycle after A leaves.
4. Flush with M and S full plus simultaneous input D -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and D never appears at the output.
5. Stall counter: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5. With CNT_W=3 held 10 cycles -> stall_cnt=7 (saturated).
6. SKID=0: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 combinationally, and emit plus accept of a new beat happen on one edge.
